// File: rtl/uart_tx_feeder_if.sv
// Write-port and transmitter-side signals of the UART feeder.
// slave is the feeder's view; master is the environment's view.
interface uart_tx_feeder_if;
  logic       i_wr_valid;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_done;

  modport master (
    output i_wr_valid, i_wr_data, i_tx_done,
    input  o_wr_ready, o_tx_start, o_tx_data
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_tx_done,
    output o_wr_ready, o_tx_start, o_tx_data
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus frame scheduler in front of a UART transmitter: presents one
// byte per frame with a single-cycle start, waits for the transmitter's done
// (or a watchdog timeout), then enforces a minimum gap before the next byte.
module uart_tx_feeder #(
  parameter int unsigned AW          = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned TO_W        = 20,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_feeder_if.slave   bus,
  input  logic              i_flush,
  output logic [AW:0]       o_level,
  output logic              o_busy,
  output logic              o_timeout_err,
  input  logic              i_err_clr
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned GAP_EFF = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
  localparam int unsigned GW      = $clog2(GAP_EFF + 1);
  localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic empty, full, wr_ready, push, pop, done_rise, wd_fire;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ready  = !full && !i_flush;
  assign push      = bus.i_wr_valid && wr_ready;
  assign done_rise = bus.i_tx_done && !done_q;

  assign o_level        = wr_ptr_q - rd_ptr_q;
  assign o_busy         = (state_q != S_IDLE) || !empty;
  assign o_timeout_err  = err_q;
  assign bus.o_wr_ready = wr_ready;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;

  // Frame scheduler: next state, byte capture, start pulse, watchdog and gap counters.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    wd_d       = wd_q;
    gap_d      = gap_q;
    pop        = 1'b0;
    wd_fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d   = S_LOAD;
          tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
          pop       = 1'b1;
        end
      end
      S_LOAD: begin
        state_d    = S_WAIT;
        tx_start_d = 1'b1;
        wd_d       = '0;
      end
      S_WAIT: begin
        if (done_rise) begin
          state_d = S_GAP;
          gap_d   = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = S_GAP;
          gap_d   = '0;
          wd_fire = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, done edge tracking and sticky timeout flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Flush blocks writes, so equalising to the current write pointer empties the queue.
    if (i_flush) rd_ptr_d = wr_ptr_q;
    done_d = bus.i_tx_done;
    if (wd_fire)        err_d = 1'b1;
    else if (i_err_clr) err_d = 1'b0;
    else                err_d = err_q;
  end

  // State and control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wd_q       <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
    end
  end

  // FIFO storage write on accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.i_wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios with random data
// and delays, plus a random traffic phase scored against a queue model where
// each start edge is predicted as max(done_edge + gap + 2, accept_edge + 2).
module tb_uart_tx_feeder;
  localparam int unsigned AW          = 4;
  localparam int unsigned GAP_CYCLES  = 0;
  localparam int unsigned TIMEOUT_CYC = 250;
  localparam int          GAP         = (GAP_CYCLES < 2) ? 2 : int'(GAP_CYCLES);
  localparam int          N_RAND      = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_err_clr = 1'b0;
  logic [AW:0] o_level;
  logic        o_busy;
  logic        o_timeout_err;

  uart_tx_feeder_if bus();

  uart_tx_feeder #(
    .AW(AW), .GAP_CYCLES(GAP_CYCLES), .TO_W(20), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_flush(i_flush),
    .o_level(o_level), .o_busy(o_busy), .o_timeout_err(o_timeout_err),
    .i_err_clr(i_err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  int         n_start = 0;
  int         last_start_cyc = -1;
  logic [7:0] last_start_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge and sample 1 time unit later; every start pulse is logged here.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.o_tx_start === 1'b1) begin
      n_start++;
      last_start_cyc  = cyc;
      last_start_data = bus.o_tx_data;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push_byte(input logic [7:0] b, output bit acc);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = b;
    acc = bus.o_wr_ready;
    tick();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic pulse_done(output int d);
    bus.i_tx_done = 1'b1;
    tick();
    d = cyc;
    bus.i_tx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget, output int at);
    int n0;
    n0 = n_start;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_start != n0) begin
        at = last_start_cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_no_start"}, 32'd0, 32'd1);
  endtask

  initial begin
    bit         acc;
    bit         hold_bad;
    bit         in_flight;
    int         n, s, s2, d, d2, at, n0, n1;
    int         sent, done_cd, last_done, exp_at;
    logic [7:0] b, x, y, z, w;
    logic [7:0] mq_d[$];
    int         mq_a[$];

    bus.i_wr_valid = 1'b0;
    bus.i_wr_data  = '0;
    bus.i_tx_done  = 1'b0;

    // Reset values
    ticks(3);
    rst_n = 1'b1;
    check("rst_start", bus.o_tx_start, 0);
    check("rst_data", bus.o_tx_data, 0);
    check("rst_level", o_level, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_timeout_err, 0);
    check("rst_ready", bus.o_wr_ready, 1);

    // Single byte, done 200 cycles after start
    b = 8'($urandom);
    push_byte(b, acc);
    n = cyc;
    check("s2_acc", acc, 1);
    check("s2_level", o_level, 1);
    wait_start("s2", 10, s);
    check("s2_latency", s, n + 2);
    check("s2_data", last_start_data, b);
    hold_bad = 1'b0;
    repeat (199) begin
      tick();
      if (bus.o_tx_data !== b || bus.o_tx_start !== 1'b0) hold_bad = 1'b1;
    end
    pulse_done(d);
    check("s2_hold", hold_bad, 0);
    check("s2_busy_gap0", o_busy, 1);
    tick();
    check("s2_busy_gap1", o_busy, 1);
    tick();
    check("s2_busy_idle", o_busy, 0);
    n0 = n_start;
    ticks(20);
    check("s2_no_restart", n_start - n0, 0);
    check("s2_data_kept", bus.o_tx_data, b);
    check("s2_err", o_timeout_err, 0);

    // Fill FIFO while a frame is stalled, then drain in order
    b = 8'($urandom);
    push_byte(b, acc);
    wait_start("s3_first", 10, s);
    check("s3_first_data", last_start_data, b);
    n0 = n_start;
    for (int i = 0; i < 17; i++) begin
      push_byte(i[7:0], acc);
      check("s3_accept", acc, (i < 16) ? 1 : 0);
    end
    check("s3_level_full", o_level, 16);
    check("s3_ready_full", bus.o_wr_ready, 0);
    check("s3_stalled", n_start - n0, 0);
    for (int k = 0; k < 16; k++) begin
      ticks($urandom_range(1, 20));
      pulse_done(d);
      wait_start("s3_frame", 20, at);
      check("s3_gap", at, d + GAP + 2);
      check("s3_data", last_start_data, k);
      check("s3_level", o_level, 15 - k);
    end
    ticks($urandom_range(1, 20));
    pulse_done(d);
    n0 = n_start;
    ticks(20);
    check("s3_no_extra", n_start - n0, 0);
    check("s3_idle", o_busy, 0);

    // Done held high: counted once, gap clamped to 2
    x = 8'($urandom); y = 8'($urandom); z = 8'($urandom); w = 8'($urandom);
    push_byte(x, acc);
    n = cyc;
    push_byte(y, acc);
    wait_start("s4_x", 10, s);
    check("s4_x_latency", s, n + 2);
    check("s4_x_data", last_start_data, x);
    ticks(5);
    bus.i_tx_done = 1'b1;
    tick();
    d = cyc;
    tick();
    bus.i_tx_done = 1'b0;
    wait_start("s4_y", 20, at);
    check("s4_y_gap", at, d + GAP + 2);
    check("s4_y_data", last_start_data, y);
    push_byte(z, acc);
    push_byte(w, acc);
    ticks(5);
    n1 = n_start;
    bus.i_tx_done = 1'b1;
    tick();
    d = cyc;
    ticks(9);
    bus.i_tx_done = 1'b0;
    check("s4_z_once", n_start - n1, 1);
    check("s4_z_gap", last_start_cyc, d + GAP + 2);
    check("s4_z_data", last_start_data, z);
    n1 = n_start;
    ticks(30);
    check("s4_level_held", n_start - n1, 0);
    check("s4_w_queued", o_level, 1);
    pulse_done(d2);
    wait_start("s4_w", 20, at);
    check("s4_w_gap", at, d2 + GAP + 2);
    check("s4_w_data", last_start_data, w);
    pulse_done(d2);
    ticks(5);
    check("s4_idle", o_busy, 0);

    // Watchdog timeout and error-clear priority
    x = 8'($urandom); y = 8'($urandom);
    push_byte(x, acc);
    push_byte(y, acc);
    wait_start("s5_t1", 10, s);
    check("s5_t1_data", last_start_data, x);
    ticks(TIMEOUT_CYC - 1);
    check("s5_err_early", o_timeout_err, 0);
    tick();
    check("s5_err_rise", o_timeout_err, 1);
    wait_start("s5_t2", 20, s2);
    check("s5_t2_at", s2, s + TIMEOUT_CYC + GAP + 2);
    check("s5_t2_data", last_start_data, y);
    n0 = n_start;
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check("s5_clr", o_timeout_err, 0);
    ticks(TIMEOUT_CYC - 2);
    check("s5_err_early2", o_timeout_err, 0);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check("s5_set_wins", o_timeout_err, 1);
    tick();
    check("s5_sticky", o_timeout_err, 1);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check("s5_clr_alone", o_timeout_err, 0);
    ticks(3);
    check("s5_idle", o_busy, 0);
    check("s5_no_extra", n_start - n0, 0);

    // Flush during a frame with a concurrent write
    b = 8'($urandom);
    push_byte(b, acc);
    wait_start("s6_f0", 10, s);
    for (int i = 0; i < 5; i++) push_byte(8'($urandom), acc);
    check("s6_level5", o_level, 5);
    n0 = n_start;
    i_flush = 1'b1;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data = 8'($urandom);
    #1;
    check("s6_ready_flush", bus.o_wr_ready, 0);
    tick();
    i_flush = 1'b0;
    bus.i_wr_valid = 1'b0;
    check("s6_level0", o_level, 0);
    check("s6_data_kept", bus.o_tx_data, b);
    ticks(3);
    check("s6_level_still0", o_level, 0);
    check("s6_busy_frame", o_busy, 1);
    pulse_done(d);
    ticks(20);
    check("s6_no_start", n_start - n0, 0);
    check("s6_idle", o_busy, 0);
    check("s6_data_end", bus.o_tx_data, b);

    // Random traffic against the queue model
    sent = 0; done_cd = 0; last_done = -1000; in_flight = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (sent >= N_RAND && mq_d.size() == 0 && !in_flight) break;
      bus.i_wr_valid = (sent < N_RAND) && ($urandom_range(0, 2) == 0);
      bus.i_wr_data  = 8'($urandom);
      bus.i_tx_done  = (done_cd == 1);
      if (done_cd > 0) done_cd--;
      acc = bus.i_wr_valid && bus.o_wr_ready;
      n0 = n_start;
      tick();
      if (acc) begin
        mq_d.push_back(bus.i_wr_data);
        mq_a.push_back(cyc);
        sent++;
      end
      if (bus.i_tx_done) begin
        last_done = cyc;
        in_flight = 1'b0;
      end
      if (n_start != n0) begin
        if (mq_d.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          exp_at = (last_done + GAP + 2 > mq_a[0] + 2) ? last_done + GAP + 2 : mq_a[0] + 2;
          check("rand_at", last_start_cyc, exp_at);
          check("rand_data", last_start_data, mq_d[0]);
          void'(mq_d.pop_front());
          void'(mq_a.pop_front());
        end
        in_flight = 1'b1;
        done_cd = $urandom_range(1, 12);
      end
    end
    bus.i_wr_valid = 1'b0;
    bus.i_tx_done = 1'b0;
    check("rand_drained", (sent == N_RAND && mq_d.size() == 0 && !in_flight) ? 1 : 0, 1);
    ticks(4);
    check("rand_level", o_level, 0);
    check("rand_idle", o_busy, 0);

    // Reset mid-frame with bytes queued
    b = 8'($urandom_range(1, 255));
    push_byte(b, acc);
    wait_start("s1", 10, s);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), acc);
    check("s1_level3", o_level, 3);
    n0 = n_start;
    rst_n = 1'b0;
    #1;
    check("s1_start", bus.o_tx_start, 0);
    check("s1_data", bus.o_tx_data, 0);
    check("s1_level", o_level, 0);
    check("s1_busy", o_busy, 0);
    check("s1_err", o_timeout_err, 0);
    ticks(2);
    rst_n = 1'b1;
    check("s1_ready", bus.o_wr_ready, 1);
    ticks(20);
    check("s1_no_start", n_start - n0, 0);
    check("s1_level_after", o_level, 0);
    check("s1_busy_after", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
